// File: rtl/otter_if_stage.sv
// Instruction Fetch stage of the pipelined OTTER CPU: owns the fetch PC, talks to a
// variable-latency instruction memory (one request in flight) and feeds IF/DE via a skid buffer.
module otter_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pc_redirect_valid,
  input  logic [31:0] pc_redirect_target,
  input  logic        de_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_de_valid,
  output logic [31:0] if_de_pc,
  output logic [31:0] if_de_ir
);

  typedef enum logic [1:0] {
    S_READY, // nothing outstanding
    S_WAIT,  // one request outstanding, response kept
    S_DRAIN  // one request outstanding, response discarded
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_ir;

  logic        de_free;
  logic        resp_keep;
  logic [31:0] target_aligned;

  assign de_free        = !if_de_valid || !de_stall;
  assign resp_keep      = (state == S_WAIT) && imem_rvalid && !pc_redirect_valid;
  assign target_aligned = pc_redirect_target & ~32'h3;

  // RESET is folded in so the request line reads low while the stage is held in reset.
  assign imem_req  = RESET && !pc_redirect_valid && !skid_valid && de_free &&
                     ((state == S_READY) || ((state == S_WAIT) && imem_rvalid));
  assign imem_addr = fetch_pc;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_READY;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      // NOTE: skid payload is reset too so nothing downstream ever observes X after reset.
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_ir     <= NOP_INSTR;
      if_de_valid <= 1'b0;
      if_de_pc    <= '0;
      if_de_ir    <= NOP_INSTR;
    end else begin
      if (imem_req) inflight_pc <= fetch_pc;

      if (pc_redirect_valid)  fetch_pc <= target_aligned;
      else if (imem_req)      fetch_pc <= fetch_pc + 32'd4;

      if (pc_redirect_valid) begin
        case (state)
          S_WAIT:  state <= imem_rvalid ? S_READY : S_DRAIN;
          S_DRAIN: if (imem_rvalid) state <= S_READY;
          default: state <= S_READY;
        endcase
      end else begin
        case (state)
          S_READY: if (imem_req) state <= S_WAIT;
          S_WAIT:  if (imem_rvalid) state <= imem_req ? S_WAIT : S_READY;
          S_DRAIN: if (imem_rvalid) state <= S_READY;
          default: state <= S_READY;
        endcase
      end

      // Redirect flushes everything; otherwise the skid drains before any fresh response.
      if (pc_redirect_valid) begin
        if_de_valid <= 1'b0;
        if_de_ir    <= NOP_INSTR;
        skid_valid  <= 1'b0;
      end else if (de_free) begin
        if (skid_valid) begin
          if_de_valid <= 1'b1;
          if_de_pc    <= skid_pc;
          if_de_ir    <= skid_ir;
          skid_valid  <= 1'b0;
        end else if (resp_keep) begin
          if_de_valid <= 1'b1;
          if_de_pc    <= inflight_pc;
          if_de_ir    <= imem_rdata;
        end else begin
          if_de_valid <= 1'b0;
          if_de_ir    <= NOP_INSTR;
        end
      end else if (resp_keep) begin
        skid_valid <= 1'b1;
        skid_pc    <= inflight_pc;
        skid_ir    <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_otter_if_stage.sv
// Bench for otter_if_stage: variable-latency memory model plus an in-order PC stream
// scoreboard, exercised by directed scenarios and a randomized stall/redirect run.
module tb_otter_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        pc_redirect_valid = 1'b0;
  logic [31:0] pc_redirect_target = '0;
  logic        de_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_de_valid;
  logic [31:0] if_de_pc;
  logic [31:0] if_de_ir;

  otter_if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RESET(RESET),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
    .de_stall(de_stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_de_valid(if_de_valid), .if_de_pc(if_de_pc), .if_de_ir(if_de_ir)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs, applied at the next step().
  logic        drv_rst_n = 1'b0;
  logic        drv_stall = 1'b0;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_target = '0;
  logic        inject_late = 1'b0;
  int          mem_lat = 1;

  // Memory model: one pending request, answered mem_lat cycles later.
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  // Reference: next PC expected on the decode stream and on the request bus.
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  logic        hold_flag = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_ir = '0;

  logic        req_fire = 1'b0;
  logic [31:0] req_addr = '0;
  logic        cons_fire = 1'b0;
  logic [31:0] cons_pc = '0;
  int          consumed = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // One clock cycle: check held outputs, drive inputs at negedge, observe settled comb outputs.
  task automatic step();
    @(negedge CLK);
    if (hold_flag && RESET) begin
      checks++;
      if (if_de_valid !== 1'b1 || if_de_pc !== hold_pc || if_de_ir !== hold_ir) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b pc=%h ir=%h, want v=1 pc=%h ir=%h",
                 if_de_valid, if_de_pc, if_de_ir, hold_pc, hold_ir);
      end
    end
    RESET              = drv_rst_n;
    de_stall           = drv_stall;
    pc_redirect_valid  = drv_redir;
    pc_redirect_target = drv_target;
    drv_redir          = 1'b0;
    imem_rvalid        = 1'b0;
    imem_rdata         = '0;
    if (!RESET) begin
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(mem_addr);
        mem_pend    = 1'b0;
      end
    end
    if (inject_late) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      inject_late = 1'b0;
    end
    if (!RESET) begin
      exp_pc  = RST_PC;
      exp_req = RST_PC;
    end else if (pc_redirect_valid) begin
      exp_pc  = {pc_redirect_target[31:2], 2'b00};
      exp_req = {pc_redirect_target[31:2], 2'b00};
    end
    #1;
    req_fire  = 1'b0;
    cons_fire = 1'b0;
    hold_flag = 1'b0;
    if (RESET) begin
      if (imem_req) begin
        req_fire = 1'b1;
        req_addr = imem_addr;
        checks++;
        if (pc_redirect_valid || mem_pend || imem_addr !== exp_req) begin
          errors++;
          $display("FAIL req_rules: got addr=%h redir=%0b outstanding=%0b, want addr=%h redir=0 outstanding=0",
                   imem_addr, pc_redirect_valid, mem_pend, exp_req);
        end
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
        exp_req  = exp_req + 32'd4;
      end
      if (if_de_valid && !de_stall && !pc_redirect_valid) begin
        cons_fire = 1'b1;
        cons_pc   = if_de_pc;
        consumed++;
        checks++;
        if (if_de_pc !== exp_pc || if_de_ir !== instr_of(exp_pc)) begin
          errors++;
          $display("FAIL stream: got pc=%h ir=%h, want pc=%h ir=%h",
                   if_de_pc, if_de_ir, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (!if_de_valid) begin
        checks++;
        if (if_de_ir !== NOP) begin
          errors++;
          $display("FAIL bubble_ir: got %h, want %h", if_de_ir, NOP);
        end
      end
      hold_flag = if_de_valid && de_stall && !pc_redirect_valid;
      hold_pc   = if_de_pc;
      hold_ir   = if_de_ir;
    end
  endtask

  task automatic do_reset(input int n);
    drv_rst_n = 1'b0;
    drv_stall = 1'b0;
    hold_flag = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (if_de_valid !== 1'b0 || if_de_pc !== 32'h0 || if_de_ir !== NOP || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%0b pc=%h ir=%h req=%0b, want v=0 pc=0 ir=%h req=0",
               tag, if_de_valid, if_de_pc, if_de_ir, imem_req, NOP);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    check_reset_outputs("reset_values");
  endtask

  task automatic test_sequential();
    logic [31:0] want [3];
    want[0] = 32'h100; want[1] = 32'h104; want[2] = 32'h108;
    mem_lat   = 1;
    drv_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (!req_fire || req_addr !== want[i]) begin
        errors++;
        $display("FAIL seq_addr%0d: got req=%0b addr=%h, want req=1 addr=%h", i, req_fire, req_addr, want[i]);
      end
      checks++;
      if (i < 2 && if_de_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_latency%0d: got valid=%0b, want 0", i, if_de_valid);
      end else if (i == 2 && (if_de_valid !== 1'b1 || if_de_pc !== 32'h100)) begin
        errors++;
        $display("FAIL seq_first: got v=%0b pc=%h, want v=1 pc=00000100", if_de_valid, if_de_pc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    drv_stall = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (if_de_valid !== 1'b1 || if_de_pc !== 32'h104 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_state: got v=%0b pc=%h req=%0b, want v=1 pc=00000104 req=0",
                 if_de_valid, if_de_pc, imem_req);
      end
    end
    drv_stall = 1'b0;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      step();
      if (cons_fire) got.push_back(cons_pc);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h104 || got[1] !== 32'h108 || got[2] !== 32'h10C) begin
      errors++;
      $display("FAIL stall_release: got %0d words (%p), want 104,108,10c", got.size(), got);
    end
  endtask

  task automatic find_first(input int budget, output logic [31:0] first_req, output logic [31:0] first_cons);
    logic have_req = 1'b0;
    logic have_cons = 1'b0;
    first_req  = 32'hFFFF_FFFF;
    first_cons = 32'hFFFF_FFFF;
    for (int i = 0; i < budget && !(have_req && have_cons); i++) begin
      step();
      if (req_fire && !have_req)   begin first_req  = req_addr; have_req  = 1'b1; end
      if (cons_fire && !have_cons) begin first_cons = cons_pc;  have_cons = 1'b1; end
    end
  endtask

  task automatic test_redirect_outstanding();
    logic        found = 1'b0;
    logic [31:0] fr, fc;
    do_reset(2);
    mem_lat   = 3;
    drv_rst_n = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (req_fire && req_addr == 32'h110) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_setup: request for 00000110 not seen within budget");
    end
    drv_redir  = 1'b1;
    drv_target = 32'h200;
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_req: got req=%0b, want 0", imem_req);
    end
    step();
    checks++;
    if (if_de_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: got valid=%0b, want 0", if_de_valid);
    end
    find_first(40, fr, fc);
    checks++;
    if (fr !== 32'h200 || fc !== 32'h200) begin
      errors++;
      $display("FAIL redir_target: got req=%h out=%h, want 00000200 both", fr, fc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] fr, fc;
    for (int i = 0; i < 20 && !(mem_pend && mem_cnt == 1); i++) step();
    checks++;
    if (!(mem_pend && mem_cnt == 1)) begin
      errors++;
      $display("FAIL same_setup: no response due within budget");
    end
    drv_redir  = 1'b1;
    drv_target = 32'h303;
    step();
    checks++;
    if (imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle: got req=%0b rvalid=%0b, want req=0 rvalid=1", imem_req, imem_rvalid);
    end
    find_first(40, fr, fc);
    checks++;
    if (fr !== 32'h300 || fc !== 32'h300) begin
      errors++;
      $display("FAIL same_target: got req=%h out=%h, want 00000300 both", fr, fc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs [$];
    mem_lat    = 1;
    drv_redir  = 1'b1;
    drv_target = 32'hFFFF_FFFC;
    for (int i = 0; i < 20 && reqs.size() < 2; i++) begin
      step();
      if (req_fire) reqs.push_back(req_addr);
    end
    checks++;
    if (reqs.size() != 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %0d requests (%p), want fffffffc,00000000", reqs.size(), reqs);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic        found = 1'b0;
    logic [31:0] fr, fc;
    do_reset(2);
    mem_lat   = 3;
    drv_rst_n = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (if_de_valid && mem_pend) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midwait_setup: valid-while-waiting state not reached");
    end
    #2;
    drv_rst_n = 1'b0;
    RESET     = 1'b0;
    hold_flag = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    drv_rst_n   = 1'b1;
    inject_late = 1'b1;
    find_first(40, fr, fc);
    checks++;
    if (fr !== RST_PC || fc !== RST_PC) begin
      errors++;
      $display("FAIL late_rvalid: got req=%h out=%h, want %h both", fr, fc, RST_PC);
    end
  endtask

  task automatic test_random();
    int base;
    do_reset(2);
    drv_rst_n = 1'b1;
    base = consumed;
    for (int i = 0; i < 1500; i++) begin
      mem_lat   = $urandom_range(1, 3);
      drv_stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < 4) begin
        drv_redir  = 1'b1;
        drv_target = $urandom;
      end
      step();
    end
    drv_stall = 1'b0;
    checks++;
    if (consumed - base < 150) begin
      errors++;
      $display("FAIL random_progress: got %0d instructions, want at least 150", consumed - base);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
